fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controller for the fetch stage. Owns the program counter and sequences instruction-memory requests over a req/ready handshake with variable latency. Applies branch redirects from the memory stage and decode-stage stalls. Buffers one returned instruction while decode is stalled and raises the IF/ID flush on a redirect.

Parameters:
N, 64, PC and address width
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of the fetch-bubble performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall_D  in  1  decode hazard stall; the instruction offered this cycle is not consumed
PCSrc_M  in  1  taken branch resolved in memory stage
PCBranch_M  in  N  branch target, valid when PCSrc_M=1
imem_ready  in  1  instruction memory returns data for the outstanding request this cycle
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_req  out  1  request outstanding
imem_addr_F  out  N  request address, equal to the current PC
fetch_valid_F  out  1  instr_F/pc_F valid and offered to IF/ID
instr_F  out  32  fetched instruction
pc_F  out  N  address of instr_F
flush_D  out  1  kill IF/ID and ID/EX contents (one-cycle pulse)
bubble_cnt  out  CNT_W  saturating count of post-reset cycles with fetch_valid_F=0

Behaviour:
- States: IDLE, REQ, HOLD, REDIR. Reset (reset=0, asynchronous) gives: state=IDLE, pc=RESET_PC, target register=0, instruction buffer=0, bubble_cnt=0. All outputs are 0 during reset, except imem_addr_F=RESET_PC.
- Address relation: imem_addr_F=pc in every state. pc+4 is computed modulo 2^N, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- IDLE: imem_req=0, fetch_valid_F=0. Goes to REQ on the next cycle unconditionally, so the first request issues one cycle after reset release.
- REQ: imem_req=1.
  - imem_ready=0, PCSrc_M=0: remain in REQ.
  - imem_ready=0, PCSrc_M=1: latch PCBranch_M into the target register, flush_D=1, go to REDIR. A memory request cannot be aborted.
  - imem_ready=1, PCSrc_M=1: drop the returned word (fetch_valid_F=0), pc<=PCBranch_M, flush_D=1, remain in REQ.
  - imem_ready=1, PCSrc_M=0: fetch_valid_F=1 in the same cycle, with instr_F=imem_rdata and pc_F=pc (combinational pass-through).
    - stall_D=0: pc<=pc+4, remain in REQ.
    - stall_D=1: latch imem_rdata into the buffer, pc unchanged, go to HOLD.
- HOLD: imem_req=0, fetch_valid_F=1, instr_F=buffer, pc_F=pc.
  - PCSrc_M=1: highest priority. pc<=PCBranch_M, flush_D=1, fetch_valid_F forced to 0, go to REQ.
  - PCSrc_M=0, stall_D=0: word consumed, pc<=pc+4, go to REQ.
  - PCSrc_M=0, stall_D=1: remain in HOLD.
- REDIR: imem_req=1 at the old pc, fetch_valid_F=0, flush_D=0.
  - A further PCSrc_M=1 overwrites the target register; the last one wins.
  - On imem_ready=1: drop the data. pc<=target, or pc<=PCBranch_M if PCSrc_M=1 in the same cycle. Go to REQ.
- flush_D: asserted only in the cycle PCSrc_M=1 is accepted in REQ or HOLD. Never asserted in IDLE or REDIR.
- PCSrc_M in IDLE: ignored. The front end is empty and no branch can be in flight.
- pc_F/instr_F: when fetch_valid_F=0 they are don't-care. The bench must not check them.
- bubble_cnt: increments every cycle with state≠IDLE and fetch_valid_F=0. Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: any state returns to IDLE immediately. An outstanding memory response arriving after reset release while in IDLE is ignored.

Test Plan:
- Zero-wait stream: reset released, imem_ready=1 every cycle. Required: imem_req rises 1 cycle after release; pc_F = 0,4,8,12 on consecutive cycles with fetch_valid_F=1; bubble_cnt=0 after the IDLE cycle.
- Wait states: imem_ready pulses every 3rd cycle. Required: pc advances by 4 only on ready cycles; bubble_cnt increments by 2 per fetched word.
- Decode stall: stall_D=1 for 3 cycles on the return of addr 0x8 with rdata 0xD503201F. Required: HOLD presents 0xD503201F/pc_F=0x8 for 3 cycles with imem_req=0; then imem_addr_F=0xC.
- Redirect during miss: PCSrc_M=1, PCBranch_M=0x100 while a request at 0x10 is pending. Then PCSrc_M=1, PCBranch_M=0x200 two cycles later; ready after 4 cycles. Required: flush_D on the first branch only; the 0x10 data is never valid; next imem_addr_F=0x200.
- Branch in HOLD and simultaneous-ready branch: PCSrc_M=1, target 0x40, in each case. Required: flush_D=1, fetch_valid_F=0 that cycle, imem_addr_F=0x40 next cycle.
- Async reset in REDIR, plus PC wrap: assert reset for half a cycle. Required: outputs clear immediately and pc=RESET_PC. Separately, RESET_PC=0xFFFF_FFFF_FFFF_FFFC with one fetch gives next imem_addr_F=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences variable-latency instruction-memory
// requests, holds one word across decode stalls and applies memory-stage redirects.
module fetch_sequencer #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_D,
  input  logic             PCSrc_M,
  input  logic [N-1:0]     PCBranch_M,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [N-1:0]     imem_addr_F,
  output logic             fetch_valid_F,
  output logic [31:0]      instr_F,
  output logic [N-1:0]     pc_F,
  output logic             flush_D,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_REDIR} state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_pc, w_pc_nxt, w_pc_inc;
  logic [N-1:0]     r_target, w_target_nxt;
  logic [31:0]      r_buf, w_buf_nxt;
  logic [CNT_W-1:0] r_bubble;

  assign w_pc_inc    = r_pc + N'(4);
  assign imem_addr_F = r_pc;
  assign bubble_cnt  = r_bubble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_target <= '0;
      r_buf    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
      r_buf    <= w_buf_nxt;
    end
  end

  // A pending memory request cannot be cancelled, so a redirect during a miss parks in REDIR.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    w_buf_nxt    = r_buf;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          if (PCSrc_M) begin
            w_pc_nxt = PCBranch_M;
          end else if (stall_D) begin
            w_buf_nxt   = imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end else if (PCSrc_M) begin
          w_target_nxt = PCBranch_M;
          w_state_nxt  = S_REDIR;
        end
      end
      S_HOLD: begin
        if (PCSrc_M) begin
          w_pc_nxt    = PCBranch_M;
          w_state_nxt = S_REQ;
        end else if (!stall_D) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end
      S_REDIR: begin
        if (PCSrc_M) w_target_nxt = PCBranch_M;
        if (imem_ready) begin
          w_pc_nxt    = PCSrc_M ? PCBranch_M : r_target;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    fetch_valid_F = 1'b0;
    instr_F       = '0;
    pc_F          = '0;
    flush_D       = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        flush_D  = PCSrc_M;
        if (imem_ready && !PCSrc_M) begin
          fetch_valid_F = 1'b1;
          instr_F       = imem_rdata;
          pc_F          = r_pc;
        end
      end
      S_HOLD: begin
        flush_D       = PCSrc_M;
        fetch_valid_F = !PCSrc_M;
        instr_F       = r_buf;
        pc_F          = r_pc;
      end
      S_REDIR: imem_req = 1'b1;
      default: ;
    endcase
  end

  // Counts empty fetch slots once the front end is running; holds at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble <= '0;
    end else if (r_state != S_IDLE && !fetch_valid_F && r_bubble != '1) begin
      r_bubble <= r_bubble + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: offered (pc, instr) pairs go through a queue
// scoreboard; control outputs are checked against per-step expected values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_D, PCSrc_M, imem_ready;
  logic [63:0] PCBranch_M;
  logic [31:0] imem_rdata;

  logic        imem_req, fetch_valid_F, flush_D;
  logic [63:0] imem_addr_F, pc_F;
  logic [31:0] instr_F;
  logic [31:0] bubble_cnt;

  logic        w_req, w_vld, w_fl;
  logic [63:0] w_addr, w_pcf;
  logic [31:0] w_ins;
  logic [1:0]  w_bub;

  fetch_sequencer #(.N(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall_D(stall_D), .PCSrc_M(PCSrc_M),
    .PCBranch_M(PCBranch_M), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr_F(imem_addr_F), .fetch_valid_F(fetch_valid_F),
    .instr_F(instr_F), .pc_F(pc_F), .flush_D(flush_D), .bubble_cnt(bubble_cnt)
  );

  // Second instance: PC wrap from the top of the address space and a tiny saturating counter.
  fetch_sequencer #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset), .stall_D(stall_D), .PCSrc_M(PCSrc_M),
    .PCBranch_M(PCBranch_M), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(w_req), .imem_addr_F(w_addr), .fetch_valid_F(w_vld),
    .instr_F(w_ins), .pc_F(w_pcf), .flush_D(w_fl), .bubble_cnt(w_bub)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return 32'hE000_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb.push_back(e);
  endtask

  // One clock step: drive inputs, check combinational outputs mid-cycle, then advance.
  task automatic cyc(input logic rdy, input logic [31:0] rd, input logic st,
                     input logic br, input logic [63:0] tgt,
                     input logic e_req, input logic [63:0] e_addr,
                     input logic e_vld, input logic e_fl);
    exp_t e;
    imem_ready = rdy;
    imem_rdata = rd;
    stall_D    = st;
    PCSrc_M    = br;
    PCBranch_M = tgt;
    #1;
    chk("imem_req", 64'(imem_req), 64'(e_req));
    chk("imem_addr_F", imem_addr_F, e_addr);
    chk("fetch_valid_F", 64'(fetch_valid_F), 64'(e_vld));
    chk("flush_D", 64'(flush_D), 64'(e_fl));
    if (fetch_valid_F === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_fetch", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("pc_F", pc_F, e.pc);
        chk("instr_F", 64'(instr_F), 64'(e.ins));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall_D    = 1'b0;
    PCSrc_M    = 1'b0;
    PCBranch_M = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    // Reset values
    chk("rst_req", 64'(imem_req), 64'(0));
    chk("rst_addr", imem_addr_F, 64'h0);
    chk("rst_valid", 64'(fetch_valid_F), 64'(0));
    chk("rst_flush", 64'(flush_D), 64'(0));
    chk("rst_instr", 64'(instr_F), 64'(0));
    chk("rst_pcF", pc_F, 64'h0);
    chk("rst_bubble", 64'(bubble_cnt), 64'(0));
    reset = 1'b1;

    // Zero-wait stream
    cyc(1'b1, mk(64'h0), 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 64'(4 * i);
      push(a, mk(a));
      cyc(1'b1, mk(a), 1'b0, 1'b0, 64'h0, 1'b1, a, 1'b1, 1'b0);
    end
    chk("stream_bubble", 64'(bubble_cnt), 64'(0));

    // Wait states: ready every third cycle
    for (int k = 0; k < 3; k++) begin
      a = 64'h10 + 64'(4 * k);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1, a, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1, a, 1'b0, 1'b0);
      push(a, mk(a));
      cyc(1'b1, mk(a), 1'b0, 1'b0, 64'h0, 1'b1, a, 1'b1, 1'b0);
      chk("wait_bubble", 64'(bubble_cnt), 64'(2 * (k + 1)));
    end

    // Decode stall on the word at 0x8
    do_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    push(64'h0, mk(64'h0));
    cyc(1'b1, mk(64'h0), 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    push(64'h4, mk(64'h4));
    cyc(1'b1, mk(64'h4), 1'b0, 1'b0, 64'h0, 1'b1, 64'h4, 1'b1, 1'b0);
    push(64'h8, 32'hD503201F);
    cyc(1'b1, 32'hD503201F, 1'b1, 1'b0, 64'h0, 1'b1, 64'h8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(64'h8, 32'hD503201F);
      cyc(1'b0, 32'h0, (i < 2), 1'b0, 64'h0, 1'b0, 64'h8, 1'b1, 1'b0);
    end
    push(64'hC, mk(64'hC));
    cyc(1'b1, mk(64'hC), 1'b0, 1'b0, 64'h0, 1'b1, 64'hC, 1'b1, 1'b0);

    // Redirect during a miss at 0x10; second branch overrides the target
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'h100, 1'b1, 64'h10, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'h200, 1'b1, 64'h10, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0,   1'b1, 64'h10, 1'b0, 1'b0);
    cyc(1'b1, mk(64'h10), 1'b0, 1'b0, 64'h0, 1'b1, 64'h10, 1'b0, 1'b0);

    // Branch coinciding with ready, then branch while holding
    cyc(1'b1, mk(64'h200), 1'b0, 1'b1, 64'h40, 1'b1, 64'h200, 1'b0, 1'b1);
    push(64'h40, mk(64'h40));
    cyc(1'b1, mk(64'h40), 1'b0, 1'b0, 64'h0, 1'b1, 64'h40, 1'b1, 1'b0);
    push(64'h44, mk(64'h44));
    cyc(1'b1, mk(64'h44), 1'b1, 1'b0, 64'h0, 1'b1, 64'h44, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 64'h40, 1'b0, 64'h44, 1'b0, 1'b1);

    // Enter REDIR, then async reset for half a cycle
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 64'h300, 1'b1, 64'h40, 1'b0, 1'b1);
    imem_ready = 1'b1;
    PCSrc_M    = 1'b1;
    PCBranch_M = 64'h500;
    reset      = 1'b0;
    #1;
    chk("arst_req", 64'(imem_req), 64'(0));
    chk("arst_addr", imem_addr_F, 64'h0);
    chk("arst_valid", 64'(fetch_valid_F), 64'(0));
    chk("arst_flush", 64'(flush_D), 64'(0));
    chk("arst_bubble", 64'(bubble_cnt), 64'(0));
    #3;
    reset   = 1'b1;
    PCSrc_M = 1'b0;
    #1;
    chk("late_rsp_valid", 64'(fetch_valid_F), 64'(0));
    chk("late_rsp_req", 64'(imem_req), 64'(0));
    @(posedge clk);
    #1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0);

    // PC wrap and counter saturation on the second instance
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("wrap_rst_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_rst_bubble", 64'(w_bub), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0);
      chk("wrap_bubble_sat", 64'(w_bub), 64'((i < 3) ? i + 1 : 3));
    end
    chk("wrap_addr_top", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    push(64'h0, mk(64'h0));
    cyc(1'b1, mk(64'h0), 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    chk("wrap_addr_next", w_addr, 64'h0);
    chk("wrap_bubble_hold", 64'(w_bub), 64'(3));

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
